adc_capture_ctrl: RTL and testbench



---
 rtl/adc_capture_ctrl.sv | 154 +++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// ADC acquisition sequencer: divided ADC clock, level trigger and wrapping sample-RAM writes with a pre/post-trigger split.
// Optional: define SCOPE_AUTO_TRIG_EN to force a trigger after 2^ADDR_W untriggered samples in WAIT_TRIG.
module adc_capture_ctrl #(
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [7:0]        iADC_Byte,
  input  logic [DIV_W-1:0]  iDivider,
  input  logic              iArm,
  input  logic [7:0]        iTrigLevel,
  input  logic              iTrigRising,
  input  logic [ADDR_W-1:0] iPostCount,
  output logic              oADC_CLK,
  output logic              oADC_nOE,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [7:0]        oWrData,
  output logic [ADDR_W-1:0] oTrigAddr,
  output logic              oBusy,
  output logic              oDone
);

  typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, DONE} state_t;

  state_t            state, stateNext;
  logic [DIV_W-1:0]  divLat, divCnt, divEff;
  logic [ADDR_W-1:0] ptr, pLat, preLat, preIn, phaseCnt;
  logic [7:0]        prevSample, levelLat;
  logic              risingLat, havePrev;
  logic              divWrap, strobe, armNow, active, trigHit, autoFire;
  logic              doWrite, trigEvent;

  assign divEff  = (divLat == '0) ? DIV_W'(1) : divLat;
  assign divWrap = (divCnt == divEff - DIV_W'(1));
  assign strobe  = divWrap & oADC_CLK;
  assign armNow  = iArm & ((state == IDLE) | (state == DONE));
  assign active  = (state == FILL) | (state == WAIT_TRIG) | (state == POST);
  // iPostCount can never exceed 2^ADDR_W-1, so PRE is simply its complement.
  assign preIn   = ~iPostCount;

  assign trigHit = havePrev & (risingLat ? ((prevSample < levelLat) && (iADC_Byte >= levelLat))
                                         : ((prevSample > levelLat) && (iADC_Byte <= levelLat)));

  assign oBusy    = active;
  assign oDone    = (state == DONE);
  assign oADC_nOE = ~active;

`ifdef SCOPE_AUTO_TRIG_EN
  logic [ADDR_W:0] waitCnt;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      waitCnt <= '0;
    end else if (state != WAIT_TRIG) begin
      waitCnt <= '0;
    end else if (strobe) begin
      waitCnt <= waitCnt + (ADDR_W+1)'(1);
    end
  end

  assign autoFire = waitCnt[ADDR_W];
`else
  assign autoFire = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    doWrite   = 1'b0;
    trigEvent = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (armNow) stateNext = (preIn == '0) ? WAIT_TRIG : FILL;
      end
      FILL: begin
        if (strobe) begin
          doWrite = 1'b1;
          if (phaseCnt == preLat - ADDR_W'(1)) stateNext = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (strobe) begin
          doWrite = 1'b1;
          if (trigHit | autoFire) begin
            trigEvent = 1'b1;
            stateNext = (pLat == '0) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (strobe) begin
          doWrite = 1'b1;
          if (phaseCnt == pLat - ADDR_W'(1)) stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= IDLE;
      divLat     <= DIV_W'(5000);
      divCnt     <= '0;
      oADC_CLK   <= 1'b0;
      ptr        <= '0;
      phaseCnt   <= '0;
      pLat       <= '0;
      preLat     <= '0;
      prevSample <= '0;
      levelLat   <= '0;
      risingLat  <= 1'b0;
      havePrev   <= 1'b0;
      oWrEn      <= 1'b0;
      oWrAddr    <= '0;
      oWrData    <= '0;
      oTrigAddr  <= '0;
    end else begin
      state    <= stateNext;
      phaseCnt <= (stateNext != state) ? '0 : phaseCnt + ADDR_W'(doWrite);
      if (armNow) begin
        divLat    <= iDivider;
        divCnt    <= '0;
        oADC_CLK  <= 1'b0;
        ptr       <= '0;
        pLat      <= iPostCount;
        preLat    <= preIn;
        levelLat  <= iTrigLevel;
        risingLat <= iTrigRising;
        havePrev  <= 1'b0;
      end else begin
        if (divWrap) begin
          divCnt   <= '0;
          oADC_CLK <= ~oADC_CLK;
        end else begin
          divCnt <= divCnt + DIV_W'(1);
        end
        if (strobe) begin
          prevSample <= iADC_Byte;
          havePrev   <= active;
        end
        if (doWrite) ptr <= ptr + ADDR_W'(1);
      end
      oWrEn <= doWrite;
      if (doWrite) begin
        oWrData <= iADC_Byte;
        oWrAddr <= ptr;
      end
      if (trigEvent) oTrigAddr <= ptr;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with ADDR_W=4 and a divider of 2 (ADC clock period 4 iCLK cycles).
module tb_adc_capture_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          iCLK = 1'b0;
  logic          iRST_n = 1'b1;
  logic [7:0]    iADC_Byte = '0;
  logic [15:0]   iDivider = 16'd2;
  logic          iArm = 1'b0;
  logic [7:0]    iTrigLevel = '0;
  logic          iTrigRising = 1'b0;
  logic [AW-1:0] iPostCount = '0;
  logic          oADC_CLK, oADC_nOE, oWrEn, oBusy, oDone;
  logic [AW-1:0] oWrAddr, oTrigAddr;
  logic [7:0]    oWrData;

  int checks = 0;
  int errors = 0;
  logic [7:0] stim [64];

  int   cyc = 0, lastRise = 0, period = 0, badStrobe = 0;
  logic prevClk = 1'b0;

  adc_capture_ctrl #(.DIV_W(16), .ADDR_W(AW)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iADC_Byte(iADC_Byte), .iDivider(iDivider),
    .iArm(iArm), .iTrigLevel(iTrigLevel), .iTrigRising(iTrigRising), .iPostCount(iPostCount),
    .oADC_CLK(oADC_CLK), .oADC_nOE(oADC_nOE), .oWrEn(oWrEn), .oWrAddr(oWrAddr),
    .oWrData(oWrData), .oTrigAddr(oTrigAddr), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iCLK = ~iCLK;

  // ADC clock period tracking and write-strobe placement relative to the ADC clock fall
  always @(negedge iCLK) begin
    cyc++;
    if (oWrEn && !(prevClk && !oADC_CLK)) badStrobe++;
    if (oADC_CLK && !prevClk) begin
      period   = cyc - lastRise;
      lastRise = cyc;
    end
    prevClk = oADC_CLK;
  end

  task automatic checkEq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitWrite(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge iCLK);
      if (oWrEn) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkEq("writeSeen", int'(ok), 1);
  endtask

  task automatic armCfg(input logic [7:0] lvl, input logic rising, input int post);
    iTrigLevel  = lvl;
    iTrigRising = rising;
    iPostCount  = post[AW-1:0];
    iADC_Byte   = stim[0];
    @(negedge iCLK);
    iArm = 1'b1;
    @(negedge iCLK);
    iArm = 1'b0;
    checkEq("busyAfterArm", oBusy, 1);
    checkEq("doneAfterArm", oDone, 0);
    checkEq("nOEAfterArm", oADC_nOE, 0);
  endtask

  task automatic runWrites(input int count, input int lastBusy);
    bit ok;
    for (int i = 0; i < count; i++) begin
      waitWrite(ok);
      if (!ok) return;
      $display("wr %0d addr=%0d data=0x%02h trigAddr=%0d", i, oWrAddr, oWrData, oTrigAddr);
      checkEq("wrAddr", oWrAddr, i % DEPTH);
      checkEq("wrData", oWrData, stim[i]);
      if (i < lastBusy) checkEq("busyDuringAcq", oBusy, 1);
      iADC_Byte = stim[i + 1];
    end
  endtask

  task automatic doAcq(input string name, input logic [7:0] lvl, input logic rising,
                       input int post, input int expTrig);
    int total, extra;
    total = expTrig + 1 + post;
    $display("acq %s: level=0x%02h rising=%0d post=%0d expect trigger at write %0d", name, lvl, rising, post, expTrig);
    armCfg(lvl, rising, post);
    runWrites(total, total - 1);
    checkEq("doneAtEnd", oDone, 1);
    checkEq("busyAtEnd", oBusy, 0);
    checkEq("nOEAtEnd", oADC_nOE, 1);
    checkEq("trigAddr", oTrigAddr, expTrig % DEPTH);
    extra = 0;
    repeat (12) begin
      @(negedge iCLK);
      if (oWrEn) extra++;
    end
    checkEq("extraWrites", extra, 0);
    checkEq("doneSticky", oDone, 1);
  endtask

  task automatic fillRamp();
    for (int i = 0; i < 64; i++) stim[i] = 8'(8'hE0 + 16 * i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bTrig, rstWr;

    #2 iRST_n = 1'b0;
    #2;
    checkEq("rstADC_CLK", oADC_CLK, 0);
    checkEq("rstNOE", oADC_nOE, 1);
    checkEq("rstWrEn", oWrEn, 0);
    checkEq("rstWrAddr", oWrAddr, 0);
    checkEq("rstWrData", oWrData, 0);
    checkEq("rstTrigAddr", oTrigAddr, 0);
    checkEq("rstBusy", oBusy, 0);
    checkEq("rstDone", oDone, 0);
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;

    // A: rising through 0x80, 10 pre-trigger samples, trigger at address 10
    fillRamp();
    doAcq("rampRising", 8'h80, 1'b1, 5, 10);
    checkEq("adcClkPeriod", period, 4);

    // B: falling at 0x40; constant 0x40 never triggers, then 0x50,0x40 does
    for (int i = 0; i < 64; i++) stim[i] = 8'h40;
    stim[30] = 8'h50;
    for (int i = 32; i < 64; i++) stim[i] = 8'h00;
`ifdef SCOPE_AUTO_TRIG_EN
    bTrig = 26;
`else
    bTrig = 31;
`endif
    doAcq("fallingConst", 8'h40, 1'b0, 5, bTrig);

    // C: PRE=0, first sample after arm must not trigger despite the low previous value
    for (int i = 0; i < 64; i++) stim[i] = 8'h20;
    stim[0] = 8'h90;
    stim[1] = 8'h10;
    stim[2] = 8'h80;
    doAcq("preZero", 8'h80, 1'b1, 15, 2);

    // D: P=0, acquisition ends on the trigger write
    for (int i = 0; i < 64; i++) stim[i] = 8'h80;
    stim[15] = 8'h30;
    doAcq("postZero", 8'h40, 1'b0, 0, 15);

    // E: asynchronous reset in the middle of POST
    fillRamp();
    $display("acq resetMidPost: abort after 13 writes");
    armCfg(8'h80, 1'b1, 5);
    runWrites(13, 13);
    @(negedge iCLK);
    #1 iRST_n = 1'b0;
    #1;
    checkEq("abortADC_CLK", oADC_CLK, 0);
    checkEq("abortNOE", oADC_nOE, 1);
    checkEq("abortWrEn", oWrEn, 0);
    checkEq("abortWrAddr", oWrAddr, 0);
    checkEq("abortWrData", oWrData, 0);
    checkEq("abortTrigAddr", oTrigAddr, 0);
    checkEq("abortBusy", oBusy, 0);
    checkEq("abortDone", oDone, 0);
    rstWr = 0;
    repeat (4) begin
      @(negedge iCLK);
      if (oWrEn) rstWr++;
    end
    checkEq("writesInReset", rstWr, 0);
    iRST_n = 1'b1;
    doAcq("rearmAfterReset", 8'h80, 1'b1, 5, 10);

    checkEq("wrEnAfterClkFall", badStrobe, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
